// File: rtl/button_pio_gen2.sv
// button_pio_gen2: synchronized button inputs with edge capture, masked level irq and register readback.
// Define BUTTON_PIO_DEBOUNCE_EN to add a per-bit debounce counter between synchronizer and edge logic.
module button_pio_gen2 #(
    parameter int WIDTH           = 4,
    parameter int EDGE_TYPE       = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_port,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [2:0]       address,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic             irq
);
    logic [WIDTH-1:0] sync1_q, sync2_q, stable, prev_q;
    logic [WIDTH-1:0] edge_capture_q, edge_capture_d, irq_mask_q, irq_mask_d;
    logic [WIDTH-1:0] edge_detect, clr, rd_sel;
    logic [31:0]      readdata_q, readdata_d;
    logic             wr;
    wire              unused_wdata;

    assign unused_wdata = ^writedata;

`ifdef BUTTON_PIO_DEBOUNCE_EN
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
    logic [CW-1:0]    cnt_q [WIDTH];
    logic [CW-1:0]    cnt_d [WIDTH];
    logic [WIDTH-1:0] stable_q, stable_d;

    // The cycle that would take the count to DEBOUNCE_CYCLES accepts the change instead, so it never wraps.
    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i]    = (sync2_q[i] == stable_q[i] || cnt_q[i] >= LAST) ? '0 : cnt_q[i] + 1'b1;
            stable_d[i] = (sync2_q[i] != stable_q[i] && cnt_q[i] >= LAST) ? sync2_q[i] : stable_q[i];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stable_q <= '0;
            cnt_q    <= '{default: '0};
        end else begin
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign stable = stable_q;
`else
    wire unused_debounce;

    assign unused_debounce = ^32'(DEBOUNCE_CYCLES);
    assign stable = sync2_q;
`endif

    always_comb begin
        wr             = chipselect & ~write_n;
        irq_mask_d     = (wr && address == 3'd2) ? writedata[WIDTH-1:0] : irq_mask_q;
        clr            = (wr && address == 3'd3) ? writedata[WIDTH-1:0] : '0;
        edge_detect    = (EDGE_TYPE == 0) ? stable & ~prev_q :
                         (EDGE_TYPE == 1) ? ~stable & prev_q : stable ^ prev_q;
        edge_capture_d = (edge_capture_q & ~clr) | edge_detect;
        rd_sel         = (address == 3'd0) ? stable :
                         (address == 3'd1) ? edge_capture_q & irq_mask_q :
                         (address == 3'd2) ? irq_mask_q :
                         (address == 3'd3) ? edge_capture_q :
                         (address == 3'd4) ? sync2_q : '0;
        readdata_d     = 32'(rd_sel);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q        <= '0;
            sync2_q        <= '0;
            prev_q         <= '0;
            irq_mask_q     <= '0;
            edge_capture_q <= '0;
            readdata_q     <= '0;
        end else begin
            sync1_q        <= in_port;
            sync2_q        <= sync1_q;
            prev_q         <= stable;
            irq_mask_q     <= irq_mask_d;
            edge_capture_q <= edge_capture_d;
            readdata_q     <= readdata_d;
        end
    end

    assign readdata = readdata_q;
    assign irq      = |(edge_capture_q & irq_mask_q);
endmodule

// File: tb/tb_button_pio_gen2.sv
// tb_button_pio_gen2: directed checks of any/rise/fall edge instances sharing one stimulus stream.
module tb_button_pio_gen2;
`ifdef BUTTON_PIO_DEBOUNCE_EN
    localparam int DL = 6;
    localparam logic [31:0] GLITCH_CAP = 32'h1;
`else
    localparam int DL = 2;
    localparam logic [31:0] GLITCH_CAP = 32'h3;
`endif
    logic        clk = 1'b0, reset = 1'b1, chipselect = 1'b0, write_n = 1'b1;
    logic [3:0]  in_port = '0;
    logic [2:0]  address = '0;
    logic [31:0] writedata = '0;
    logic [31:0] rd_a, rd_r, rd_f;
    logic        irq_a, irq_r, irq_f;
    int          n_cmp = 0, n_bad = 0;

    button_pio_gen2 u_any (.clk(clk), .reset(reset), .in_port(in_port), .chipselect(chipselect),
        .write_n(write_n), .address(address), .writedata(writedata), .readdata(rd_a), .irq(irq_a));
    button_pio_gen2 #(.EDGE_TYPE(0)) u_rise (.clk(clk), .reset(reset), .in_port(in_port), .chipselect(chipselect),
        .write_n(write_n), .address(address), .writedata(writedata), .readdata(rd_r), .irq(irq_r));
    button_pio_gen2 #(.EDGE_TYPE(1)) u_fall (.clk(clk), .reset(reset), .in_port(in_port), .chipselect(chipselect),
        .write_n(write_n), .address(address), .writedata(writedata), .readdata(rd_f), .irq(irq_f));

    always #5 clk = ~clk;

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic rd(input logic [2:0] a);
        address = a;
        tick();
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = a;
        writedata  = d;
        tick();
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    initial begin
        tick(3);
        reset = 1'b0;
        for (int a = 0; a < 8; a++) begin
            rd(3'(a));
            chk($sformatf("reset_rd%0d", a), rd_a, 32'h0);
        end
        chk("reset_irq", 32'(irq_a), 32'h0);

        // bit0 rises: debounced value visible on readdata one cycle after it settles
        in_port = 4'h1;
        address = 3'd0;
        tick(DL);
        chk("rise_data_early", rd_a, 32'h0);
        tick();
        chk("rise_data_latency", rd_a, 32'h1);
        tick(10);
        rd(3);
        chk("rise_cap_any", rd_a, 32'h1);
        chk("rise_cap_rise", rd_r, 32'h1);
        chk("rise_cap_fall", rd_f, 32'h0);
        chk("rise_irq_masked", 32'(irq_a), 32'h0);

        // 3-cycle pulse on bit1: rejected only when debouncing
        in_port = 4'h3;
        tick(3);
        in_port = 4'h1;
        tick(12);
        rd(0);
        chk("glitch_data", rd_a, 32'h1);
        rd(3);
        chk("glitch_cap", rd_a, GLITCH_CAP);
        chk("glitch_irq", 32'(irq_a), 32'h0);

        // all four bits change; selective clear, mask, irq
        wr(3, 32'hF);
        in_port = 4'hE;
        tick(DL + 3);
        rd(3);
        chk("all_cap_any", rd_a, 32'hF);
        chk("all_cap_rise", rd_r, 32'hE);
        chk("all_cap_fall", rd_f, 32'h1);
        wr(3, 32'h5);
        rd(3);
        chk("w1c_any", rd_a, 32'hA);
        chk("w1c_rise", rd_r, 32'hA);
        chk("w1c_fall", rd_f, 32'h0);
        rd(1);
        chk("status_nomask", rd_a, 32'h0);
        chk("irq_nomask", 32'(irq_a), 32'h0);
        wr(2, 32'h2);
        chk("irq_unmask_same_cycle", 32'(irq_a), 32'h1);
        chk("irq_unmask_rise", 32'(irq_r), 32'h1);
        chk("irq_unmask_fall", 32'(irq_f), 32'h0);
        rd(1);
        chk("status_masked", rd_a, 32'h2);
        wr(2, 32'hFFFF_FFF2);
        rd(2);
        chk("mask_upper_ignored", rd_a, 32'h2);
        wr(5, 32'hFFFF_FFFF);
        rd(5);
        chk("addr5_reads0", rd_a, 32'h0);
        rd(2);
        chk("addr5_write_ignored", rd_a, 32'h2);
        rd(4);
        chk("raw", rd_a, 32'hE);
        rd(0);
        chk("data", rd_a, 32'hE);
        wr(3, 32'h2);
        chk("irq_cleared", 32'(irq_a), 32'h0);
        rd(3);
        chk("cap_after_clr", rd_a, 32'h8);

        // clear of bit0 lands on the same edge that captures a new bit0 edge
        in_port = 4'hF;
        tick(DL);
        wr(3, 32'h1);
        rd(3);
        chk("set_wins_any", rd_a, 32'h9);
        chk("set_wins_rise", rd_r, 32'h9);
        chk("set_wins_fall", rd_f, 32'h0);
        wr(3, 32'h1);
        rd(3);
        chk("plain_clear", rd_a, 32'h8);

        // bit2 rises then falls: falling-edge instance captures only after the fall
        in_port = 4'hB;
        tick(DL + 3);
        wr(3, 32'hF);
        in_port = 4'hF;
        tick(DL + 3);
        rd(3);
        chk("b2_rise_fall_inst", rd_f, 32'h0);
        chk("b2_rise_rise_inst", rd_r, 32'h4);
        chk("b2_rise_any_inst", rd_a, 32'h4);
        in_port = 4'hB;
        tick(DL + 3);
        rd(3);
        chk("b2_fall_fall_inst", rd_f, 32'h4);
        chk("b2_fall_rise_inst", rd_r, 32'h4);

        // reset in the middle of a pending change restarts the full latency
        in_port = 4'h0;
        tick(DL + 3);
        in_port = 4'h1;
        tick(4);
        reset = 1'b1;
        tick();
        chk("midreset_rd", rd_a, 32'h0);
        chk("midreset_irq", 32'(irq_a), 32'h0);
        reset = 1'b0;
        address = 3'd0;
        tick(DL);
        chk("midreset_data_early", rd_a, 32'h0);
        tick();
        chk("midreset_data_latency", rd_a, 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
